// File: rtl/parking_entry_ctrl_pkg.sv
// Shared parking types and constants: gate FSM states, default capacity and the door cycle length
// owned jointly with the door block.
package parking_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOpen,
    StHold,
    StWaitClear
  } state_e;

  localparam int unsigned CAPACITY_DEFAULT  = 8;
  localparam int unsigned DOOR_HOLD_DEFAULT = 22;
  localparam int unsigned OCC_WIDTH         = 4;

endpackage

// File: rtl/parking_entry_ctrl_if.sv
// Sensor inputs and gate/status outputs of the entry controller.
interface parking_entry_ctrl_if;
  import parking_entry_ctrl_pkg::*;

  logic                 entry_sensor;
  logic                 exit_sensor;
  logic                 open_signal;
  logic [OCC_WIDTH-1:0] free_spaces;
  logic                 full;
  logic                 reject_led;

  // Sensor/stimulus side.
  modport master (
    output entry_sensor,
    output exit_sensor,
    input  open_signal,
    input  free_spaces,
    input  full,
    input  reject_led
  );

  // Controller side.
  modport slave (
    input  entry_sensor,
    input  exit_sensor,
    output open_signal,
    output free_spaces,
    output full,
    output reject_led
  );
endinterface

// File: rtl/parking_entry_ctrl_occupancy_counter.sv
// Saturating occupancy counter; an increment and a decrement on the same edge cancel out.
module occupancy_counter
  import parking_entry_ctrl_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEFAULT
) (
  input  logic                 clk_2Hz,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  output logic [OCC_WIDTH-1:0] count_next,
  output logic [OCC_WIDTH-1:0] free,
  output logic                 full
);

  localparam logic [OCC_WIDTH-1:0] Cap = OCC_WIDTH'(CAPACITY);

  logic [OCC_WIDTH-1:0] count_q, count_d;
  logic [OCC_WIDTH-1:0] free_q;
  logic                 full_q;

  always_comb begin
    count_d = count_q;
    case ({inc, dec})
      2'b10:   if (count_q < Cap) count_d = count_q + 1'b1;
      2'b01:   if (count_q != '0) count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_2Hz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      free_q  <= Cap;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      free_q  <= Cap - count_d;
      full_q  <= (count_d == Cap);
    end
  end

  assign count_next = count_d;
  assign free       = free_q;
  assign full       = full_q;

endmodule

// File: rtl/parking_entry_ctrl.sv
// Entry gate controller: debounces the entry sensor, issues the door open pulse, holds off for the
// door cycle, and tracks occupancy from entry and exit events.
module parking_entry_ctrl
  import parking_entry_ctrl_pkg::*;
#(
  parameter int unsigned CAPACITY  = CAPACITY_DEFAULT,
  parameter int unsigned DEBOUNCE  = 2,
  parameter int unsigned DOOR_HOLD = DOOR_HOLD_DEFAULT
) (
  input logic                 clk_2Hz,
  input logic                 reset,
  parking_entry_ctrl_if.slave bus
);

  localparam int unsigned HoldW = $clog2(DOOR_HOLD + 1);

  state_e               state_q;
  logic [2:0]           deb_q;
  logic [HoldW-1:0]     hold_q;
  logic                 open_q;
  logic                 reject_q;
  logic                 exit_q;

  logic [3:0]           deb_plus;
  logic                 deb_hit;
  logic                 enter_open;
  logic                 exit_edge;
  logic                 occ_full;
  logic [OCC_WIDTH-1:0] occ_next;
  logic [OCC_WIDTH-1:0] occ_free;

  assign deb_plus   = {1'b0, deb_q} + 4'd1;
  assign deb_hit    = (deb_plus >= 4'(DEBOUNCE));
  // Registered full blocks entry even if an exit lands on the same edge.
  assign enter_open = (state_q == StIdle) && bus.entry_sensor && deb_hit && !occ_full;
  assign exit_edge  = bus.exit_sensor && !exit_q;

  occupancy_counter #(
    .CAPACITY(CAPACITY)
  ) u_occupancy_counter (
    .clk_2Hz   (clk_2Hz),
    .reset     (reset),
    .inc       (enter_open),
    .dec       (exit_edge),
    .count_next(occ_next),
    .free      (occ_free),
    .full      (occ_full)
  );

  always_ff @(posedge clk_2Hz or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      deb_q    <= '0;
      hold_q   <= '0;
      open_q   <= 1'b0;
      reject_q <= 1'b0;
      exit_q   <= 1'b0;
    end else begin
      exit_q   <= bus.exit_sensor;
      reject_q <= bus.entry_sensor && (occ_next == OCC_WIDTH'(CAPACITY));
      open_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!bus.entry_sensor) begin
            deb_q <= '0;
          end else if (enter_open) begin
            state_q <= StOpen;
            open_q  <= 1'b1;
            deb_q   <= '0;
          end else if (deb_hit) begin
            // Lot is full: park the count at threshold so entry fires once a space frees.
            deb_q <= 3'(DEBOUNCE);
          end else begin
            deb_q <= deb_plus[2:0];
          end
        end
        StOpen: begin
          state_q <= StHold;
          hold_q  <= HoldW'(DOOR_HOLD - 1);
        end
        StHold: begin
          if (hold_q == '0) state_q <= StWaitClear;
          else              hold_q  <= hold_q - 1'b1;
        end
        StWaitClear: begin
          if (!bus.entry_sensor) begin
            state_q <= StIdle;
            deb_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.open_signal = open_q;
  assign bus.free_spaces = occ_free;
  assign bus.full        = occ_full;
  assign bus.reject_led  = reject_q;

endmodule

// File: tb/tb_parking_entry_ctrl.sv
// Directed bench for parking_entry_ctrl with default parameters (CAPACITY 8, DEBOUNCE 2, hold 22).
module tb_parking_entry_ctrl;

  logic clk_2Hz;
  logic reset;
  int   tests;
  int   fails;
  int   pulses;

  parking_entry_ctrl_if bus ();

  parking_entry_ctrl dut (
    .clk_2Hz(clk_2Hz),
    .reset  (reset),
    .bus    (bus)
  );

  initial begin
    clk_2Hz = 1'b0;
    forever #5 clk_2Hz = ~clk_2Hz;
  end

  task automatic tick();
    @(posedge clk_2Hz);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count open pulses over n ticks.
  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.open_signal === 1'b1) pulses++;
    end
  endtask

  // One car admitted, then sensor released and the door cycle allowed to finish.
  task automatic entry_car(input string tag);
    bus.entry_sensor = 1'b1;
    tick();
    check({tag, "_deb"}, int'(bus.open_signal), 0);
    tick();
    check({tag, "_open"}, int'(bus.open_signal), 1);
    bus.entry_sensor = 1'b0;
    repeat (25) tick();
  endtask

  task automatic exit_car();
    bus.exit_sensor = 1'b1;
    tick();
    bus.exit_sensor = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.entry_sensor = 1'b0;
    bus.exit_sensor  = 1'b0;
    repeat (2) tick();
    check("rst_open", int'(bus.open_signal), 0);
    check("rst_free", int'(bus.free_spaces), 8);
    check("rst_full", int'(bus.full), 0);
    check("rst_reject", int'(bus.reject_led), 0);
    reset = 1'b0;

    // First entry: pulse on the second high sample.
    bus.entry_sensor = 1'b1;
    tick();
    check("e1_first_sample", int'(bus.open_signal), 0);
    check("e1_free_before", int'(bus.free_spaces), 8);
    tick();
    check("e1_open", int'(bus.open_signal), 1);
    check("e1_free", int'(bus.free_spaces), 7);
    pulses = 0;
    run_count(30);
    check("hold_no_pulse", pulses, 0);
    check("hold_free", int'(bus.free_spaces), 7);

    // Release then re-present: WAIT_CLEAR returns to IDLE.
    bus.entry_sensor = 1'b0;
    tick();
    bus.entry_sensor = 1'b1;
    tick();
    check("e2_deb", int'(bus.open_signal), 0);
    tick();
    check("e2_open", int'(bus.open_signal), 1);
    check("e2_free", int'(bus.free_spaces), 6);
    bus.entry_sensor = 1'b0;
    repeat (25) tick();

    for (int i = 0; i < 6; i++) entry_car("fill");
    check("full_flag", int'(bus.full), 1);
    check("full_free", int'(bus.free_spaces), 0);
    check("full_reject_idle", int'(bus.reject_led), 0);

    // Ninth car rejected while full.
    bus.entry_sensor = 1'b1;
    tick();
    check("rej_led", int'(bus.reject_led), 1);
    check("rej_open", int'(bus.open_signal), 0);
    pulses = 0;
    run_count(3);
    check("rej_no_pulse", pulses, 0);
    bus.exit_sensor = 1'b1;
    tick();
    check("rej_exit_full", int'(bus.full), 0);
    check("rej_exit_free", int'(bus.free_spaces), 1);
    check("rej_exit_open", int'(bus.open_signal), 0);
    check("rej_exit_led", int'(bus.reject_led), 0);
    tick();
    check("rej_admit_open", int'(bus.open_signal), 1);
    check("rej_admit_free", int'(bus.free_spaces), 0);
    check("rej_admit_full", int'(bus.full), 1);
    bus.exit_sensor  = 1'b0;
    bus.entry_sensor = 1'b0;
    repeat (25) tick();
    check("rej_led_clear", int'(bus.reject_led), 0);

    repeat (3) exit_car();
    check("occ5_free", int'(bus.free_spaces), 3);

    // Entry and exit on the same edge cancel.
    bus.entry_sensor = 1'b1;
    tick();
    bus.exit_sensor = 1'b1;
    tick();
    check("sim_open", int'(bus.open_signal), 1);
    check("sim_free", int'(bus.free_spaces), 3);
    bus.exit_sensor  = 1'b0;
    bus.entry_sensor = 1'b0;
    repeat (25) tick();
    check("sim_free_after", int'(bus.free_spaces), 3);

    repeat (5) exit_car();
    check("empty_free", int'(bus.free_spaces), 8);
    repeat (2) exit_car();
    check("empty_sat_free", int'(bus.free_spaces), 8);
    check("empty_sat_full", int'(bus.full), 0);

    // Single-sample glitch.
    pulses = 0;
    bus.entry_sensor = 1'b1;
    run_count(1);
    bus.entry_sensor = 1'b0;
    run_count(4);
    check("glitch_pulse", pulses, 0);
    check("glitch_free", int'(bus.free_spaces), 8);

    // Reset mid-HOLD with occupancy 3.
    entry_car("pre_a");
    entry_car("pre_b");
    bus.entry_sensor = 1'b1;
    tick();
    tick();
    check("pre_c_open", int'(bus.open_signal), 1);
    check("pre_c_free", int'(bus.free_spaces), 5);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("hrst_open", int'(bus.open_signal), 0);
    check("hrst_free", int'(bus.free_spaces), 8);
    check("hrst_full", int'(bus.full), 0);
    check("hrst_reject", int'(bus.reject_led), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_deb", int'(bus.open_signal), 0);
    tick();
    check("post_open", int'(bus.open_signal), 1);
    check("post_free", int'(bus.free_spaces), 7);

    // Reset mid-OPEN drops the pulse at once.
    #2;
    reset = 1'b1;
    #1;
    check("orst_open", int'(bus.open_signal), 0);
    check("orst_free", int'(bus.free_spaces), 8);
    tick();
    reset = 1'b0;
    bus.entry_sensor = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
